// File: rtl/alu_result_writeback_if.sv
// ALU result writeback bundle: upstream result push, register-file write port,
// HI/LO, condition flags and occupancy. Master drives results/ack, slave is the stage.
interface alu_result_writeback_if #(
    parameter int DEPTH = 2
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_control;
    logic [3:0]       in_dest;
    logic [63:0]      in_result;
    logic             rf_wr_en;
    logic [3:0]       rf_wr_addr;
    logic [31:0]      rf_wr_data;
    logic             rf_wr_ack;
    logic [31:0]      hi_out;
    logic [31:0]      lo_out;
    logic             flag_z;
    logic             flag_n;
    logic [CNT_W-1:0] count;

    modport master (
        output in_valid, in_control, in_dest, in_result, rf_wr_ack,
        input  in_ready, rf_wr_en, rf_wr_addr, rf_wr_data,
        input  hi_out, lo_out, flag_z, flag_n, count
    );

    modport slave (
        input  in_valid, in_control, in_dest, in_result, rf_wr_ack,
        output in_ready, rf_wr_en, rf_wr_addr, rf_wr_data,
        output hi_out, lo_out, flag_z, flag_n, count
    );
endinterface

// File: rtl/alu_result_writeback.sv
// Buffers ALU results in a small FIFO and retires them to the register file,
// to HI/LO (MUL/DIV) or discards them (R0), updating zero/negative flags on retire.
module alu_result_writeback #(
    parameter int         DEPTH  = 2,
    parameter logic [4:0] OP_MUL = 5'b01110,
    parameter logic [4:0] OP_DIV = 5'b01111
) (
    input logic                  Clock,
    input logic                  Clear,
    alu_result_writeback_if.slave wb
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [4:0]  control;
        logic [3:0]  dest;
        logic [63:0] result;
    } entry_t;

    typedef enum logic [1:0] {IDLE, WRITE, HILO} state_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             in_ready_q, in_ready_d;
    state_t           state_q, state_d;
    logic             rf_wr_en_q, rf_wr_en_d;
    logic [3:0]       rf_wr_addr_q, rf_wr_addr_d;
    logic [31:0]      rf_wr_data_q, rf_wr_data_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic             flag_z_q, flag_z_d, flag_n_q, flag_n_d;

    entry_t head;
    logic   push, pop, head_muldiv;

    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        state_d      = state_q;
        rf_wr_en_d   = rf_wr_en_q;
        rf_wr_addr_d = rf_wr_addr_q;
        rf_wr_data_d = rf_wr_data_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        flag_z_d     = flag_z_q;
        flag_n_d     = flag_n_q;
        pop          = 1'b0;
        head         = mem_q[rd_ptr_q];
        head_muldiv  = (head.control == OP_MUL) || (head.control == OP_DIV);
        // in_ready is the registered view of occupancy, so a same-cycle pop never frees a slot
        push         = wb.in_valid & in_ready_q;

        if (push) begin
            mem_d[wr_ptr_q] = '{control: wb.in_control, dest: wb.in_dest, result: wb.in_result};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    if (head_muldiv) begin
                        state_d = HILO;
                    end else if (head.dest != 4'd0) begin
                        rf_wr_addr_d = head.dest;
                        rf_wr_data_d = head.result[31:0];
                        rf_wr_en_d   = 1'b1;
                        state_d      = WRITE;
                    end else begin
                        pop      = 1'b1;
                        flag_z_d = (head.result[31:0] == 32'd0);
                        flag_n_d = head.result[31];
                    end
                end
            end
            WRITE: begin
                if (wb.rf_wr_ack) begin
                    pop        = 1'b1;
                    rf_wr_en_d = 1'b0;
                    flag_z_d   = (head.result[31:0] == 32'd0);
                    flag_n_d   = head.result[31];
                    state_d    = IDLE;
                end
            end
            HILO: begin
                hi_d     = head.result[63:32];
                lo_d     = head.result[31:0];
                pop      = 1'b1;
                flag_z_d = (head.result == 64'd0);
                flag_n_d = head.result[63];
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (!push && pop) count_d = count_q - CNT_W'(1);

        in_ready_d = (count_d < CNT_W'(DEPTH));
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            in_ready_q   <= 1'b0;
            state_q      <= IDLE;
            rf_wr_en_q   <= 1'b0;
            rf_wr_addr_q <= '0;
            rf_wr_data_q <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            flag_z_q     <= 1'b0;
            flag_n_q     <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            in_ready_q   <= in_ready_d;
            state_q      <= state_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_wr_addr_q <= rf_wr_addr_d;
            rf_wr_data_q <= rf_wr_data_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            flag_z_q     <= flag_z_d;
            flag_n_q     <= flag_n_d;
        end
    end

    assign wb.in_ready   = in_ready_q;
    assign wb.count      = count_q;
    assign wb.rf_wr_en   = rf_wr_en_q;
    assign wb.rf_wr_addr = rf_wr_addr_q;
    assign wb.rf_wr_data = rf_wr_data_q;
    assign wb.hi_out     = hi_q;
    assign wb.lo_out     = lo_q;
    assign wb.flag_z     = flag_z_q;
    assign wb.flag_n     = flag_n_q;
endmodule

// File: tb/tb_alu_result_writeback.sv
// Directed bench for alu_result_writeback: ADD, MUL, R0 discard, backpressure,
// simultaneous push/pop with pointer wrap, and asynchronous reset mid-write.
module tb_alu_result_writeback;
    logic Clock = 1'b0;
    logic Clear;
    int   total = 0;
    int   bad   = 0;

    always #5 Clock = ~Clock;

    alu_result_writeback_if #(.DEPTH(2)) wb ();

    alu_result_writeback #(.DEPTH(2)) dut (
        .Clock (Clock),
        .Clear (Clear),
        .wb    (wb)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] c, input logic [3:0] d, input logic [63:0] r);
        wb.in_valid   = v;
        wb.in_control = c;
        wb.in_dest    = d;
        wb.in_result  = r;
    endtask

    logic [63:0] r6  [5];
    logic        ez6 [5];
    logic        en6 [5];

    initial begin
        r6[0] = 64'h1234_5678_8000_0001; ez6[0] = 1'b0; en6[0] = 1'b1;
        r6[1] = 64'hFFFF_FFFF_0000_0000; ez6[1] = 1'b1; en6[1] = 1'b0;
        r6[2] = 64'h0000_0000_7FFF_FFFF; ez6[2] = 1'b0; en6[2] = 1'b0;
        r6[3] = 64'h0000_0001_FFFF_FFFE; ez6[3] = 1'b0; en6[3] = 1'b1;
        r6[4] = 64'h8000_0000_0000_0042; ez6[4] = 1'b0; en6[4] = 1'b0;

        Clear        = 1'b0;
        wb.rf_wr_ack = 1'b0;
        drive(1'b0, 5'd0, 4'd0, 64'd0);

        // reset state
        step();
        step();
        chk("rst_count", wb.count, 0);
        chk("rst_in_ready", wb.in_ready, 0);
        chk("rst_rf_wr_en", wb.rf_wr_en, 0);
        chk("rst_addr_data", {wb.rf_wr_addr, wb.rf_wr_data}, 0);
        chk("rst_hilo", {wb.hi_out, wb.lo_out}, 0);
        chk("rst_flags", {wb.flag_z, wb.flag_n}, 0);
        Clear = 1'b1;
        step();
        chk("rel_in_ready", wb.in_ready, 1);

        // ADD dest 3
        drive(1'b1, 5'b00000, 4'd3, 64'h8);
        step();
        drive(1'b0, 5'd0, 4'd0, 64'd0);
        chk("add_count1", wb.count, 1);
        chk("add_en_early", wb.rf_wr_en, 0);
        step();
        chk("add_en", wb.rf_wr_en, 1);
        chk("add_addr", wb.rf_wr_addr, 3);
        chk("add_data", wb.rf_wr_data, 64'h8);
        wb.rf_wr_ack = 1'b1;
        step();
        wb.rf_wr_ack = 1'b0;
        chk("add_en_drop", wb.rf_wr_en, 0);
        chk("add_count0", wb.count, 0);
        chk("add_flags", {wb.flag_z, wb.flag_n}, 2'b00);

        // MUL to HI/LO
        drive(1'b1, 5'b01110, 4'd5, 64'hFFFF_FFFF_0000_0000);
        step();
        drive(1'b0, 5'd0, 4'd0, 64'd0);
        chk("mul_en_a", wb.rf_wr_en, 0);
        step();
        chk("mul_en_b", wb.rf_wr_en, 0);
        step();
        chk("mul_en_c", wb.rf_wr_en, 0);
        chk("mul_hi", wb.hi_out, 64'hFFFF_FFFF);
        chk("mul_lo", wb.lo_out, 0);
        chk("mul_flags", {wb.flag_z, wb.flag_n}, 2'b01);
        chk("mul_count", wb.count, 0);

        // R0 discard
        drive(1'b1, 5'b00000, 4'd0, 64'd0);
        step();
        drive(1'b0, 5'd0, 4'd0, 64'd0);
        chk("r0_count1", wb.count, 1);
        step();
        chk("r0_count0", wb.count, 0);
        chk("r0_en", wb.rf_wr_en, 0);
        chk("r0_flags", {wb.flag_z, wb.flag_n}, 2'b10);
        chk("r0_hilo_kept", {wb.hi_out, wb.lo_out}, 64'hFFFF_FFFF_0000_0000);

        // backpressure: third push refused while full
        drive(1'b1, 5'b00001, 4'd1, 64'h11);
        step();
        chk("bp_ready_after1", wb.in_ready, 1);
        drive(1'b1, 5'b00001, 4'd2, 64'h22);
        step();
        chk("bp_count2", wb.count, 2);
        chk("bp_ready_full", wb.in_ready, 0);
        drive(1'b1, 5'b00001, 4'd3, 64'h33);
        step();
        drive(1'b0, 5'd0, 4'd0, 64'd0);
        chk("bp_count_hold", wb.count, 2);
        chk("bp_stall_en", wb.rf_wr_en, 1);
        chk("bp_stall_ad", {wb.rf_wr_addr, wb.rf_wr_data}, {4'd1, 32'h11});
        wb.rf_wr_ack = 1'b1;
        step();
        wb.rf_wr_ack = 1'b0;
        chk("bp_ack_count", wb.count, 1);
        chk("bp_ack_ready", wb.in_ready, 1);
        chk("bp_ack_flags", {wb.flag_z, wb.flag_n}, 2'b00);
        step();
        chk("bp_second_ad", {wb.rf_wr_en, wb.rf_wr_addr, wb.rf_wr_data}, {1'b1, 4'd2, 32'h22});
        wb.rf_wr_ack = 1'b1;
        step();
        wb.rf_wr_ack = 1'b0;
        chk("bp_drain_count", wb.count, 0);
        step();
        step();
        chk("bp_third_absent", {wb.rf_wr_en, wb.count}, 0);

        // simultaneous push/pop on ack edge, pointer wrap over 5 retires
        drive(1'b1, 5'b00010, 4'd1, r6[0]);
        step();
        drive(1'b0, 5'd0, 4'd0, 64'd0);
        step();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("wrap_wr_%0d", k),
                {wb.rf_wr_en, wb.rf_wr_addr, wb.rf_wr_data},
                {1'b1, 4'(k + 1), r6[k][31:0]});
            wb.rf_wr_ack = 1'b1;
            if (k < 4) drive(1'b1, 5'b00010, 4'(k + 2), r6[k + 1]);
            step();
            wb.rf_wr_ack = 1'b0;
            drive(1'b0, 5'd0, 4'd0, 64'd0);
            chk($sformatf("wrap_count_%0d", k), wb.count, (k < 4) ? 1 : 0);
            chk($sformatf("wrap_flags_%0d", k), {wb.flag_z, wb.flag_n}, {ez6[k], en6[k]});
            if (k < 4) step();
        end

        // asynchronous reset mid-WRITE with two entries buffered
        drive(1'b1, 5'b00000, 4'd7, 64'h77);
        step();
        drive(1'b1, 5'b00000, 4'd8, 64'h88);
        step();
        drive(1'b0, 5'd0, 4'd0, 64'd0);
        chk("pre_rst_state", {wb.rf_wr_en, wb.count}, {1'b1, 2'd2});
        #2;
        Clear = 1'b0;
        #1;
        chk("mid_rst_count", wb.count, 0);
        chk("mid_rst_en", wb.rf_wr_en, 0);
        chk("mid_rst_ready", wb.in_ready, 0);
        chk("mid_rst_hilo", {wb.hi_out, wb.lo_out}, 0);
        chk("mid_rst_flags", {wb.flag_z, wb.flag_n}, 0);
        step();
        Clear = 1'b1;
        step();
        step();
        chk("post_rst_idle", {wb.in_ready, wb.rf_wr_en, wb.count}, {1'b1, 1'b0, 2'd0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
